// File: rtl/obs_sprite_rom.sv
// obs_sprite_rom: sprite ROM responder for the obstacle renderer.
// Serves four 16x16 obstacle bitmaps on the {y[3:0], x[3:0]} address bus.
// Variant and animation phase change only on frame starts, so a sprite never
// tears mid-frame. A pseudo-random variant is picked whenever the obstacle respawns.
// Optional feature macro: OBS_BIRD_EN. It enables the animated bird as variant 3,
// along with its animation counter.
module obs_sprite_rom #(
    parameter int unsigned ANIM_FRAMES = 8,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rom_counter,
    output logic       o_sprite_color,
    input  logic       i_frame_start,
    input  logic       i_respawn,
    output logic [1:0] o_variant,
    output logic       o_anim_phase
);

    typedef enum logic [1:0] {
        V_SMALL  = 2'd0,
        V_TALL   = 2'd1,
        V_DOUBLE = 2'd2,
        V_BIRD   = 2'd3
    } variant_t;

    // Elaboration-time guard on the legal parameter ranges.
    if (ANIM_FRAMES < 1 || ANIM_FRAMES > 255 || LFSR_SEED == 8'h00) begin : g_bad_params
        $error("obs_sprite_rom: ANIM_FRAMES must be 1..255 and LFSR_SEED nonzero");
    end

    logic [7:0] lfsr;
    variant_t   sampled;
    variant_t   pending;
    variant_t   active;
    logic       pending_valid;
    logic [3:0] px;
    logic [3:0] py;

    assign px = i_rom_counter[3:0];
    assign py = i_rom_counter[7:4];

`ifdef OBS_BIRD_EN
    assign sampled = variant_t'(lfsr[1:0]);
`else
    // Without the bird, a draw of 3 falls back to the small cactus.
    assign sampled = (lfsr[1:0] == 2'd3) ? V_SMALL : variant_t'(lfsr[1:0]);
`endif

    // Free-running LFSR that supplies the random variant draws.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values; blocking here would create order races.
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Queue a variant on respawn and commit it at the next frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= V_SMALL;
            pending_valid <= 1'b0;
            active        <= V_SMALL;
        end else if (i_respawn && i_frame_start) begin
            // The respawn lands exactly on a frame boundary, so commit the draw directly.
            pending       <= sampled;
            pending_valid <= 1'b0;
            active        <= sampled;
        end else if (i_respawn) begin
            pending       <= sampled;
            pending_valid <= 1'b1;
        end else if (i_frame_start && pending_valid) begin
            active        <= pending;
            pending_valid <= 1'b0;
        end
    end

    assign o_variant = active;

`ifdef OBS_BIRD_EN
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

    logic [7:0] anim_count;
    logic       anim_phase;

    // Count frame starts and flip the bird phase every ANIM_FRAMES of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            anim_count <= 8'd0;
            anim_phase <= 1'b0;
        end else if (i_frame_start) begin
            if (anim_count == ANIM_LAST) begin
                anim_count <= 8'd0;
                anim_phase <= ~anim_phase;
            end else begin
                anim_count <= anim_count + 8'd1;
            end
        end
    end

    assign o_anim_phase = anim_phase;
`else
    assign o_anim_phase = 1'b0;
`endif

    // Pixel lookup; stays combinational because the renderer samples in the same cycle.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives the
        // output, so no latch is inferred for unlisted cases.
        o_sprite_color = 1'b0;
        case (active)
            V_SMALL:  o_sprite_color = ((px == 4'd7 || px == 4'd8) && py >= 4'd4) ||
                                       (py == 4'd8 && px >= 4'd5 && px <= 4'd10);
            V_TALL:   o_sprite_color = (px == 4'd7 || px == 4'd8) ||
                                       (py == 4'd6 && px >= 4'd4 && px <= 4'd11);
            V_DOUBLE: o_sprite_color = (px == 4'd3 || px == 4'd4 || px == 4'd11 || px == 4'd12) &&
                                       py >= 4'd6;
`ifdef OBS_BIRD_EN
            V_BIRD:   o_sprite_color = (py == 4'd7 && px >= 4'd2 && px <= 4'd13) ||
                                       (px == 4'd9 && (anim_phase ? (py >= 4'd8 && py <= 4'd11)
                                                                  : (py >= 4'd3 && py <= 4'd6)));
`endif
            default:  o_sprite_color = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_obs_sprite_rom.sv
// Self-checking bench for obs_sprite_rom: table-driven reset bitmap vectors,
// hand-written multi-cycle sequences, and randomized traffic against a
// frame-count / painted-bitmap reference model.
module tb_obs_sprite_rom;

`ifdef OBS_BIRD_EN
    localparam bit bird_en = 1'b1;
`else
    localparam bit bird_en = 1'b0;
`endif
    localparam int anim_frames = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_rom_counter = 8'h00;
    logic       o_sprite_color;
    logic       i_frame_start = 1'b0;
    logic       i_respawn = 1'b0;
    logic [1:0] o_variant;
    logic       o_anim_phase;

    int n_tests = 0;
    int n_fail  = 0;

    obs_sprite_rom #(.ANIM_FRAMES(anim_frames), .LFSR_SEED(8'hA5)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rom_counter  (i_rom_counter),
        .o_sprite_color (o_sprite_color),
        .i_frame_start  (i_frame_start),
        .i_respawn      (i_respawn),
        .o_variant      (o_variant),
        .o_anim_phase   (o_anim_phase)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic       bmp [4][2][16][16];   // [variant][phase][y][x]
    logic [7:0] m_lfsr;
    int         m_variant;
    int         m_pending;
    bit         m_pvalid;
    int         m_frames;             // frame starts since the last reset

    function automatic void paint(int v, int p, int x0, int x1, int y0, int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                bmp[v][p][y][x] = 1'b1;
    endfunction

    function automatic void build_bitmaps();
        for (int v = 0; v < 4; v++)
            for (int p = 0; p < 2; p++)
                for (int y = 0; y < 16; y++)
                    for (int x = 0; x < 16; x++)
                        bmp[v][p][y][x] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            paint(0, p, 7, 8, 4, 15);  paint(0, p, 5, 10, 8, 8);
            paint(1, p, 7, 8, 0, 15);  paint(1, p, 4, 11, 6, 6);
            paint(2, p, 3, 4, 6, 15);  paint(2, p, 11, 12, 6, 15);
            paint(3, p, 2, 13, 7, 7);
        end
        paint(3, 0, 9, 9, 3, 6);
        paint(3, 1, 9, 9, 8, 11);
    endfunction

    function automatic int model_phase();
        return bird_en ? ((m_frames / anim_frames) % 2) : 0;
    endfunction

    function automatic logic model_pixel(logic [7:0] addr);
        return bmp[m_variant][model_phase()][addr[7:4]][addr[3:0]];
    endfunction

    function automatic void model_step(logic r, logic resp, logic fs);
        int s;
        if (r) begin
            m_lfsr = 8'hA5; m_variant = 0; m_pending = 0; m_pvalid = 0; m_frames = 0;
            return;
        end
        s = int'(m_lfsr % 4);
        if (!bird_en && s == 3) s = 0;
        if (resp && fs) begin
            m_variant = s; m_pvalid = 0;
        end else if (resp) begin
            m_pending = s; m_pvalid = 1;
        end else if (fs && m_pvalid) begin
            m_variant = m_pending; m_pvalid = 0;
        end
        if (fs) m_frames++;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic resp, input logic fs);
        rst = r; i_respawn = resp; i_frame_start = fs;
        @(posedge clk);
        model_step(r, resp, fs);
        #1;
        rst = 1'b0; i_respawn = 1'b0; i_frame_start = 1'b0;
    endtask

    task automatic check_pixel(input string name, input logic [7:0] addr, input logic exp);
        i_rom_counter = addr;
        #1;
        check(name, int'(o_sprite_color), int'(exp));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       color;
    } vec_t;

    vec_t reset_vecs [4];

    initial begin
        build_bitmaps();
        reset_vecs[0] = '{8'h47, 1'b1};
        reset_vecs[1] = '{8'h46, 1'b0};
        reset_vecs[2] = '{8'h85, 1'b1};
        reset_vecs[3] = '{8'h03, 1'b0};

        // Reset bitmap check
        do_reset();
        check("reset_variant", int'(o_variant), 0);
        check("reset_phase", int'(o_anim_phase), 0);
        for (int i = 0; i < 4; i++)
            check_pixel($sformatf("reset_pix_%02h", reset_vecs[i].addr),
                        reset_vecs[i].addr, reset_vecs[i].color);

        // Deferred variant switch
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        check("deferred_hold", int'(o_variant), 0);
        cycle(1'b0, 1'b0, 1'b0);
        check("deferred_hold2", int'(o_variant), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("deferred_switch", int'(o_variant), 1);
        check_pixel("tall_07", 8'h07, 1'b1);
        check_pixel("tall_64", 8'h64, 1'b1);

        // Last respawn wins, then same-cycle bypass
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("last_wins_hold", int'(o_variant), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("last_wins", int'(o_variant), 2);
        cycle(1'b0, 1'b1, 1'b1);
        check("bypass", int'(o_variant), 2);
        check_pixel("double_63", 8'h63, 1'b1);
        check_pixel("double_53", 8'h53, 1'b0);

        // Bird animation (or its absence)
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("bird_variant", int'(o_variant), bird_en ? 3 : 0);
        check_pixel("bird_79", 8'h79, bird_en ? 1'b1 : 1'b0);
        check_pixel("bird_39", 8'h39, bird_en ? 1'b1 : 1'b0);
        check_pixel("bird_89", 8'h89, bird_en ? 1'b0 : 1'b1);
        for (int i = 0; i < 7; i++) begin
            check("bird_phase_pre", int'(o_anim_phase), 0);
            cycle(1'b0, 1'b0, 1'b1);
        end
        check("bird_phase_flip", int'(o_anim_phase), bird_en ? 1 : 0);
        check_pixel("bird_39_p1", 8'h39, 1'b0);
        check_pixel("bird_89_p1", 8'h89, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check("phase_track", int'(o_anim_phase), model_phase());
        end
        check("bird_variant_hold", int'(o_variant), bird_en ? 3 : 0);

        // Mid-frame reset discards the pending variant
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("midreset_variant", int'(o_variant), 0);
        cycle(1'b0, 1'b0, 1'b1);
        check("midreset_no_pending", int'(o_variant), 0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1);
        check("lfsr_restart", int'(o_variant), 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, resp, fs;
            logic [7:0] a;
            r    = ($urandom_range(0, 199) == 0);
            resp = ($urandom_range(0, 7) == 0);
            fs   = ($urandom_range(0, 9) == 0);
            a    = 8'($urandom);
            cycle(r, resp, fs);
            check("rnd_variant", int'(o_variant), m_variant);
            check("rnd_phase", int'(o_anim_phase), model_phase());
            check_pixel("rnd_pixel", a, model_pixel(a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
